// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and helpers for the memory access unit
//
// Holds the access-width encoding, the access FSM state encoding and the
// byte-lane helpers used by mem_access and mem_lane_align.
package mem_pkg;

  typedef enum logic [1:0] {
    W_BYTE  = 2'b00,
    W_HALF  = 2'b01,
    W_WORD  = 2'b10,
    W_DWORD = 2'b11
  } mem_width_e;

  typedef enum logic [2:0] {
    IDLE,
    BEAT0,
    WAIT0,
    BEAT1,
    WAIT1,
    RESP
  } mem_state_e;

  // Number of byte lanes on a bus of the given width.
  function automatic int lane_count(input int data_w);
    return data_w / 8;
  endfunction

  // Access size in bytes for a width code.
  function automatic int size_bytes(input mem_width_e w);
    return 1 << int'(w);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - byte-lane positioning and load extraction
//
// Purely combinational.
//   off        in   byte offset of the access inside its bus word
//   width      in   access width code
//   sign_ext   in   sign-extend the load result
//   store_data in   LSB-aligned store data
//   rd_lo      in   read data of the first beat
//   rd_hi      in   read data of the second beat (zero if unsplit)
//   strobe_lo  out  byte strobe of the first beat
//   strobe_hi  out  byte strobe of the second beat
//   wdata      out  lane-positioned, width-replicated store data
//   load_data  out  extracted load bytes at bit 0, extended to DATA_W
module mem_lane_align
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  localparam int NB = lane_count(DATA_W),
  localparam int LB = $clog2(NB)
) (
  input  logic [LB-1:0]     off,
  input  mem_width_e        width,
  input  logic              sign_ext,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] rd_lo,
  input  logic [DATA_W-1:0] rd_hi,
  output logic [NB-1:0]     strobe_lo,
  output logic [NB-1:0]     strobe_hi,
  output logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] load_data
);

  int                  size;
  int                  bits;
  int                  idx;
  logic [2*NB-1:0]     mask2;
  logic [2*DATA_W-1:0] cat;
  logic [DATA_W-1:0]   low;
  logic                fill;

  always_comb begin
    size  = size_bytes(width);
    bits  = 8 * size;
    mask2 = '0;
    wdata = '0;
    idx   = 0;

    // Strobe over a double-width window; the upper half is the second beat.
    for (int k = 0; k < 2 * NB; k++) begin
      mask2[k] = (k >= int'(off)) && (k < int'(off) + size);
    end
    strobe_lo = mask2[NB-1:0];
    strobe_hi = mask2[2*NB-1:NB];

    // Lane j carries data byte (j - off) mod size: replication for aligned
    // accesses, and the correct rotation for both halves of a split one.
    for (int j = 0; j < NB; j++) begin
      idx = (j - int'(off)) & (size - 1);
      wdata[8*j +: 8] = store_data[8*idx +: 8];
    end

    cat       = {rd_hi, rd_lo} >> (8 * int'(off));
    low       = (bits >= DATA_W) ? '1 : ((DATA_W'(1) << bits) - DATA_W'(1));
    fill      = sign_ext && cat[bits-1];
    load_data = (cat[DATA_W-1:0] & low) | (fill ? ~low : '0);
  end

endmodule

// File: rtl/mem_access.sv
// rtl/mem_access.sv - load/store unit converting requests to bus beats
//
// Optional feature macro: MEM_ACCESS_MISALIGN_SPLIT_EN (split accesses that
// cross a bus word into two beats; otherwise misaligned accesses are illegal).
//   clk_i, rstn_i                  clock, synchronous active-low reset
//   req_valid_i/req_ready_o        request handshake
//   req_write_i/width/signed/addr/data  request fields
//   bus_valid_o/bus_ready_i        bus beat handshake
//   bus_write_o/addr_o/wdata_o/strobe_o  bus beat fields
//   bus_rvalid_i/bus_rdata_i       one completion per accepted beat
//   rsp_valid_o/rsp_ready_i        response handshake
//   rsp_data_o/rsp_illegal_o       load result, illegal-access flag
module mem_access
  import mem_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_write_i,
  input  logic [1:0]          req_width_i,
  input  logic                req_signed_i,
  input  logic [ADDR_W-1:0]   req_addr_i,
  input  logic [DATA_W-1:0]   req_data_i,
  output logic                bus_valid_o,
  input  logic                bus_ready_i,
  output logic                bus_write_o,
  output logic [ADDR_W-1:0]   bus_addr_o,
  output logic [DATA_W-1:0]   bus_wdata_o,
  output logic [DATA_W/8-1:0] bus_strobe_o,
  input  logic                bus_rvalid_i,
  input  logic [DATA_W-1:0]   bus_rdata_i,
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_data_o,
  output logic                rsp_illegal_o
);

  localparam int NB = lane_count(DATA_W);
  localparam int LB = $clog2(NB);

  mem_state_e        state_q, state_d;
  logic              write_q, signed_q, rsp_illegal_q;
  mem_width_e        width_q;
  logic [ADDR_W-1:0] addr_q, addr0;
  logic [DATA_W-1:0] data_q, rdata0_q, rsp_data_q;
  logic              illegal_req, split;
  logic [NB-1:0]     strobe_lo, strobe_hi;
  logic [DATA_W-1:0] wdata_pos, load_data, rd_lo, rd_hi;

  always_comb begin
    illegal_req = (req_width_i == 2'b11) && (DATA_W == 32);
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
    split = (int'(addr_q[LB-1:0]) + size_bytes(width_q)) > NB;
`else
    illegal_req = illegal_req ||
                  (|(req_addr_i[3:0] & ((4'd1 << req_width_i) - 4'd1)));
    split = 1'b0;
`endif
  end

  // The second beat's read data arrives live; the first is held in rdata0_q.
  assign rd_lo = (state_q == WAIT1) ? rdata0_q : bus_rdata_i;
  assign rd_hi = (state_q == WAIT1) ? bus_rdata_i : '0;

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .off        (addr_q[LB-1:0]),
    .width      (width_q),
    .sign_ext   (signed_q),
    .store_data (data_q),
    .rd_lo      (rd_lo),
    .rd_hi      (rd_hi),
    .strobe_lo  (strobe_lo),
    .strobe_hi  (strobe_hi),
    .wdata      (wdata_pos),
    .load_data  (load_data)
  );

  always_ff @(posedge clk_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    req_ready_o = 1'b0;
    bus_valid_o = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) state_d = illegal_req ? RESP : BEAT0;
      end
      BEAT0: begin
        bus_valid_o = 1'b1;
        if (bus_ready_i) state_d = WAIT0;
      end
      WAIT0: if (bus_rvalid_i) state_d = split ? BEAT1 : RESP;
      BEAT1: begin
        bus_valid_o = 1'b1;
        if (bus_ready_i) state_d = WAIT1;
      end
      WAIT1: if (bus_rvalid_i) state_d = RESP;
      RESP: begin
        rsp_valid_o = 1'b1;
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      write_q       <= 1'b0;
      signed_q      <= 1'b0;
      width_q       <= W_BYTE;
      addr_q        <= '0;
      data_q        <= '0;
      rdata0_q      <= '0;
      rsp_data_q    <= '0;
      rsp_illegal_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (req_valid_i) begin
          write_q       <= req_write_i;
          signed_q      <= req_signed_i;
          width_q       <= mem_width_e'(req_width_i);
          addr_q        <= req_addr_i;
          data_q        <= req_data_i;
          rsp_illegal_q <= illegal_req;
          rsp_data_q    <= '0;
        end
        WAIT0: if (bus_rvalid_i) begin
          rdata0_q <= bus_rdata_i;
          if (!split) rsp_data_q <= write_q ? '0 : load_data;
        end
        WAIT1: if (bus_rvalid_i) rsp_data_q <= write_q ? '0 : load_data;
        default: ;
      endcase
    end
  end

  assign addr0         = {addr_q[ADDR_W-1:LB], {LB{1'b0}}};
  assign bus_addr_o    = (state_q == BEAT1) ? addr0 + ADDR_W'(NB) : addr0;
  assign bus_write_o   = write_q;
  assign bus_wdata_o   = wdata_pos;
  assign bus_strobe_o  = !write_q            ? '0 :
                         (state_q == BEAT0)  ? strobe_lo :
                         (state_q == BEAT1)  ? strobe_hi : '0;
  assign rsp_data_o    = rsp_data_q;
  assign rsp_illegal_o = rsp_illegal_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - self-checking bench for mem_access (DATA_W=32)
module tb_mem_access;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;
`ifdef MEM_ACCESS_MISALIGN_SPLIT_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic              clk_i, rstn_i;
  logic              req_valid_i, req_ready_o, req_write_i, req_signed_i;
  logic [1:0]        req_width_i;
  logic [ADDR_W-1:0] req_addr_i;
  logic [DATA_W-1:0] req_data_i;
  logic              bus_valid_o, bus_ready_i, bus_write_o;
  logic [ADDR_W-1:0] bus_addr_o;
  logic [DATA_W-1:0] bus_wdata_o;
  logic [3:0]        bus_strobe_o;
  logic              bus_rvalid_i;
  logic [DATA_W-1:0] bus_rdata_i;
  logic              rsp_valid_o, rsp_ready_i, rsp_illegal_o;
  logic [DATA_W-1:0] rsp_data_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_access #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk_i, .rstn_i,
    .req_valid_i, .req_ready_o, .req_write_i, .req_width_i, .req_signed_i,
    .req_addr_i, .req_data_i,
    .bus_valid_o, .bus_ready_i, .bus_write_o, .bus_addr_o, .bus_wdata_o,
    .bus_strobe_o, .bus_rvalid_i, .bus_rdata_i,
    .rsp_valid_o, .rsp_ready_i, .rsp_data_o, .rsp_illegal_o
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_req_ready"}, req_ready_o, 1);
    chk({tag, "_bus_valid"}, bus_valid_o, 0);
    chk({tag, "_bus_write"}, bus_write_o, 0);
    chk({tag, "_bus_addr"}, bus_addr_o, 0);
    chk({tag, "_bus_wdata"}, bus_wdata_o, 0);
    chk({tag, "_bus_strobe"}, bus_strobe_o, 0);
    chk({tag, "_rsp_valid"}, rsp_valid_o, 0);
    chk({tag, "_rsp_data"}, rsp_data_o, 0);
    chk({tag, "_rsp_illegal"}, rsp_illegal_o, 0);
  endtask

  // One complete access; expectations come from the byte-level rules.
  task automatic access(input bit wr, input logic [1:0] w, input bit sg,
                        input logic [31:0] addr, input logic [31:0] data,
                        input logic [31:0] rd0, input logic [31:0] rd1,
                        input int rdy_dly, input int rsp_dly, input bit early);
    int          size, off, nbeats, pos, gap;
    bit          illegal;
    logic [31:0] exp_addr [2];
    logic [3:0]  exp_strb [2];
    logic [31:0] rd [2];
    logic [31:0] rep, exp_wdata, exp_rsp;
    logic [63:0] tmp;
    logic [7:0]  b8;
    longint      val;

    size    = 1 << w;
    off     = int'(addr % 4);
    illegal = (w == 2'b11) || (!SPLIT && (addr % size) != 0);
    nbeats  = illegal ? 0 : ((off + size > 4) ? 2 : 1);
    exp_addr[0] = addr - off;
    exp_addr[1] = exp_addr[0] + 32'd4;
    exp_strb[0] = '0;
    exp_strb[1] = '0;
    rd[0] = rd0;
    rd[1] = rd1;
    val = 0;
    if (!illegal) begin
      for (int k = 0; k < size; k++) begin
        pos = off + k;
        if (wr) exp_strb[pos / 4][pos % 4] = 1'b1;
        b8  = rd[pos / 4][8 * (pos % 4) +: 8];
        val = val | (longint'(b8) << (8 * k));
      end
      if (sg && val[8 * size - 1]) val = val - (longint'(1) << (8 * size));
    end
    exp_rsp = (wr || illegal) ? 32'd0 : val[31:0];
    case (size)
      1:       rep = {4{data[7:0]}};
      2:       rep = {2{data[15:0]}};
      default: rep = data;
    endcase
    tmp       = {rep, rep} << (8 * off);
    exp_wdata = tmp[63:32];

    chk("req_ready_idle", req_ready_o, 1);
    req_valid_i  = 1'b1;
    req_write_i  = wr;
    req_width_i  = w;
    req_signed_i = sg;
    req_addr_i   = addr;
    req_data_i   = data;
    step();
    req_valid_i  = 1'b0;
    req_addr_i   = $urandom;
    req_data_i   = $urandom;
    req_write_i  = 1'($urandom);

    if (illegal) chk("illegal_no_beat", bus_valid_o, 0);
    for (int b = 0; b < nbeats; b++) begin
      for (int s = 0; s <= rdy_dly; s++) begin
        if (s > 0) step();
        chk("bus_valid", bus_valid_o, 1);
        chk("req_ready_busy", req_ready_o, 0);
        chk("bus_addr", bus_addr_o, exp_addr[b]);
        chk("bus_strobe", bus_strobe_o, exp_strb[b]);
        chk("bus_write", bus_write_o, wr);
        if (wr) chk("bus_wdata", bus_wdata_o, exp_wdata);
      end
      bus_ready_i  = 1'b1;
      bus_rvalid_i = early;
      bus_rdata_i  = $urandom;
      step();
      bus_ready_i  = 1'b0;
      bus_rvalid_i = 1'b0;
      chk("after_accept_bus_valid", bus_valid_o, 0);
      chk("after_accept_rsp_valid", rsp_valid_o, 0);
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        bus_rdata_i = $urandom;
        step();
        chk("wait_rsp_valid", rsp_valid_o, 0);
      end
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = rd[b];
      step();
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = $urandom;
    end

    for (int s = 0; s <= rsp_dly; s++) begin
      if (s > 0) step();
      chk("rsp_valid", rsp_valid_o, 1);
      chk("rsp_data", rsp_data_o, exp_rsp);
      chk("rsp_illegal", rsp_illegal_o, illegal);
      chk("rsp_req_ready", req_ready_o, 0);
      chk("rsp_bus_valid", bus_valid_o, 0);
    end
    rsp_ready_i = 1'b1;
    step();
    rsp_ready_i = 1'b0;
    chk("rsp_done", rsp_valid_o, 0);
    chk("back_idle", req_ready_o, 1);
  endtask

  initial begin
    logic [1:0]  w;
    logic [31:0] a;
    rstn_i       = 1'b0;
    req_valid_i  = 1'b0;
    req_write_i  = 1'b0;
    req_width_i  = 2'b00;
    req_signed_i = 1'b0;
    req_addr_i   = '0;
    req_data_i   = '0;
    bus_ready_i  = 1'b0;
    bus_rvalid_i = 1'b0;
    bus_rdata_i  = '0;
    rsp_ready_i  = 1'b0;
    step();
    step();
    chk_reset_values("reset");
    rstn_i = 1'b1;
    step();

    // SB 0x5A to 0x1003
    access(1'b1, 2'b00, 1'b0, 32'h1003, 32'hFFFF_FF5A, '0, '0, 0, 0, 1'b0);
    // LH signed / unsigned at 0x2002
    access(1'b0, 2'b01, 1'b1, 32'h2002, '0, 32'h8001_1234, '0, 0, 0, 1'b0);
    access(1'b0, 2'b01, 1'b0, 32'h2002, '0, 32'h8001_5678, '0, 0, 0, 1'b0);
    // LW at 0x3002 (split or illegal)
    access(1'b0, 2'b10, 1'b0, 32'h3002, '0, 32'hBBAA_1111, 32'h2222_DDCC, 0, 0, 1'b0);
    // Width 11 load is illegal
    access(1'b0, 2'b11, 1'b0, 32'h5000, '0, '0, '0, 0, 0, 1'b0);
    // Bus and response back-pressure
    access(1'b1, 2'b10, 1'b0, 32'h6004, 32'hCAFE_F00D, '0, '0, 3, 2, 1'b0);
    access(1'b0, 2'b00, 1'b1, 32'h7001, '0, 32'h0000_8000, '0, 3, 2, 1'b1);
    // Second beat address wraps
    access(1'b0, 2'b10, 1'b1, 32'hFFFF_FFFE, '0, 32'h8765_0000, 32'h0000_4321, 1, 1, 1'b1);
    // Split store across a word boundary
    access(1'b1, 2'b10, 1'b0, 32'h8003, 32'h4433_2211, '0, '0, 0, 0, 1'b0);

    // Reset while waiting for the first completion
    req_valid_i = 1'b1;
    req_write_i = 1'b0;
    req_width_i = 2'b10;
    req_addr_i  = 32'h4000;
    step();
    req_valid_i = 1'b0;
    bus_ready_i = 1'b1;
    step();
    bus_ready_i = 1'b0;
    rstn_i      = 1'b0;
    step();
    chk_reset_values("wait0_reset");
    rstn_i       = 1'b1;
    bus_rvalid_i = 1'b1;
    bus_rdata_i  = 32'h1234_5678;
    step();
    bus_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("post_reset_no_rsp", rsp_valid_o, 0);
      chk("post_reset_idle", req_ready_o, 1);
      step();
    end

    for (int i = 0; i < 60; i++) begin
      w = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a = a & ~((32'd1 << w) - 32'd1);
      access(1'($urandom), w, 1'($urandom), a, $urandom, $urandom, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
